// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, latency, operand/result widths.
// Ports: none (package imported by the arbiter and its response FIFO).
package alu_pkg;

    localparam int ALU_LAT = 2;
    localparam int OPND_W  = 8;
    localparam int RES_W   = 16;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_AND  = 3'b011,
        OP_XOR  = 3'b100,
        OP_OR   = 3'b101,
        OP_PASS = 3'b110,
        OP_ADD  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic v;
        logic id;
    } tag_t;

endpackage

// File: rtl/alu_arb_rsp_fifo.sv
// First-word-fall-through response FIFO, one per requester.
// Ports: clk/reset, i_push/i_data write side, i_pop/o_valid/o_data read side.
module alu_arb_rsp_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk_p_i,
    input  logic             reset_n_i,
    input  logic             i_push,
    input  logic [RES_W-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [RES_W-1:0] o_data
);

    localparam int AW = $clog2(DEPTH);

    logic [RES_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;
    logic             w_pop;

    assign o_valid = (r_cnt != '0);
    assign w_pop   = i_pop && o_valid;
    // Drive zero while empty so the output is clean out of reset.
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            unique case ({i_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_p_i) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared 2-cycle ALU with
// credit-controlled per-requester response FIFOs.
// Ports: reqN_* request handshakes, rspN_* response handshakes,
// alu_* shared ALU bus, grantN_cnt_o only when ALU_ARB_PERF_EN is defined.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int RESP_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk_p_i,
    input  logic              reset_n_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [OPND_W-1:0] req0_a_i,
    input  logic [OPND_W-1:0] req0_b_i,
    input  logic [2:0]        req0_inst_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [OPND_W-1:0] req1_a_i,
    input  logic [OPND_W-1:0] req1_b_i,
    input  logic [2:0]        req1_inst_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [RES_W-1:0]  rsp0_data_o,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [RES_W-1:0]  rsp1_data_o,
    output logic [OPND_W-1:0] alu_data_a_o,
    output logic [OPND_W-1:0] alu_data_b_o,
    output logic [2:0]        alu_inst_o,
    input  logic [RES_W-1:0]  alu_data_i
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]  grant0_cnt_o,
    output logic [CNT_W-1:0]  grant1_cnt_o
`endif
);

    localparam int CW = $clog2(RESP_DEPTH) + 1;

    if (RESP_DEPTH < 2 || (RESP_DEPTH & (RESP_DEPTH - 1)) != 0
        || CNT_W < 1) begin : g_bad_cfg
        $error("alu_arbiter: invalid RESP_DEPTH/CNT_W");
    end

    logic [CW-1:0] r_cred0, r_cred1;
    tag_t          r_tag [ALU_LAT];
    // 1 = req1 accepted last; reset value makes req0 win the first tie.
    logic          r_last;
    // Holds off issue for the first cycle after reset release.
    logic          r_run;

    logic w_elig0, w_elig1;
    logic w_gnt0, w_gnt1;
    logic w_pop0, w_pop1;
    logic w_push0, w_push1;

    assign w_elig0 = r_run && req0_valid_i && (r_cred0 < CW'(RESP_DEPTH));
    assign w_elig1 = r_run && req1_valid_i && (r_cred1 < CW'(RESP_DEPTH));
    assign w_gnt0  = w_elig0 && (!w_elig1 || r_last);
    assign w_gnt1  = w_elig1 && (!w_elig0 || !r_last);

    assign req0_ready_o = w_gnt0;
    assign req1_ready_o = w_gnt1;

    assign w_pop0  = rsp0_valid_o && rsp0_ready_i;
    assign w_pop1  = rsp1_valid_o && rsp1_ready_i;
    assign w_push0 = r_tag[ALU_LAT-1].v && !r_tag[ALU_LAT-1].id;
    assign w_push1 = r_tag[ALU_LAT-1].v &&  r_tag[ALU_LAT-1].id;

    always_comb begin
        alu_data_a_o = '0;
        alu_data_b_o = '0;
        alu_inst_o   = OP_NOP;
        unique case (1'b1)
            w_gnt0: begin
                alu_data_a_o = req0_a_i;
                alu_data_b_o = req0_b_i;
                alu_inst_o   = req0_inst_i;
            end
            w_gnt1: begin
                alu_data_a_o = req1_a_i;
                alu_data_b_o = req1_b_i;
                alu_inst_o   = req1_inst_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_run  <= 1'b0;
            r_last <= 1'b1;
            for (int i = 0; i < ALU_LAT; i++) r_tag[i] <= '0;
        end else begin
            r_run    <= 1'b1;
            r_tag[0] <= '{v: w_gnt0 || w_gnt1, id: w_gnt1};
            for (int i = 1; i < ALU_LAT; i++) r_tag[i] <= r_tag[i-1];
            if (w_gnt0) r_last <= 1'b0;
            if (w_gnt1) r_last <= 1'b1;
        end
    end

    // A credit is taken at acceptance and returned the cycle after a pop.
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cred0 <= '0;
            r_cred1 <= '0;
        end else begin
            unique case ({w_gnt0, w_pop0})
                2'b10:   r_cred0 <= r_cred0 + CW'(1);
                2'b01:   r_cred0 <= r_cred0 - CW'(1);
                default: ;
            endcase
            unique case ({w_gnt1, w_pop1})
                2'b10:   r_cred1 <= r_cred1 + CW'(1);
                2'b01:   r_cred1 <= r_cred1 - CW'(1);
                default: ;
            endcase
        end
    end

    alu_arb_rsp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo0 (
        .clk_p_i   (clk_p_i),
        .reset_n_i (reset_n_i),
        .i_push    (w_push0),
        .i_data    (alu_data_i),
        .i_pop     (rsp0_ready_i),
        .o_valid   (rsp0_valid_o),
        .o_data    (rsp0_data_o)
    );

    alu_arb_rsp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo1 (
        .clk_p_i   (clk_p_i),
        .reset_n_i (reset_n_i),
        .i_push    (w_push1),
        .i_data    (alu_data_i),
        .i_pop     (rsp1_ready_i),
        .o_valid   (rsp1_valid_o),
        .o_data    (rsp1_data_o)
    );

`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] r_gcnt0, r_gcnt1;

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_gcnt0 <= '0;
            r_gcnt1 <= '0;
        end else begin
            if (w_gnt0 && !(&r_gcnt0)) r_gcnt0 <= r_gcnt0 + CNT_W'(1);
            if (w_gnt1 && !(&r_gcnt1)) r_gcnt1 <= r_gcnt1 + CNT_W'(1);
        end
    end

    assign grant0_cnt_o = r_gcnt0;
    assign grant1_cnt_o = r_gcnt1;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural 2-cycle ALU.
// Ports: none (top-level bench).
module tb_alu_arbiter;

    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0] d;
        int          acc;
    } exp_t;

    logic        clk_p_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        rq_v   [2] = '{1'b0, 1'b0};
    logic [7:0]  rq_a   [2] = '{8'h0, 8'h0};
    logic [7:0]  rq_b   [2] = '{8'h0, 8'h0};
    logic [2:0]  rq_op  [2] = '{3'h0, 3'h0};
    logic        rs_rdy [2] = '{1'b1, 1'b1};
    logic        rdy    [2];
    logic        rsv    [2];
    logic [15:0] rsd    [2];
    logic [7:0]  alu_data_a_o, alu_data_b_o;
    logic [2:0]  alu_inst_o;
    logic [15:0] alu_data_i;
    logic [15:0] alu_s1 = '0, alu_s2 = '0;
`ifdef ALU_ARB_PERF_EN
    logic [15:0] gc0, gc1;
`endif

    int   checks = 0, errors = 0, cyc = 0;
    int   acc_cnt [2] = '{0, 0};
    int   pops    [2] = '{0, 0};
    int   gm      [2] = '{0, 0};
    int   mcred   [2] = '{0, 0};
    int   mlast = 1, rel = 0;
    int   log_q [$];
    exp_t q0 [$];
    exp_t q1 [$];

    alu_arbiter #(.RESP_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk_p_i      (clk_p_i),
        .reset_n_i    (reset_n_i),
        .req0_valid_i (rq_v[0]),
        .req0_ready_o (rdy[0]),
        .req0_a_i     (rq_a[0]),
        .req0_b_i     (rq_b[0]),
        .req0_inst_i  (rq_op[0]),
        .req1_valid_i (rq_v[1]),
        .req1_ready_o (rdy[1]),
        .req1_a_i     (rq_a[1]),
        .req1_b_i     (rq_b[1]),
        .req1_inst_i  (rq_op[1]),
        .rsp0_valid_o (rsv[0]),
        .rsp0_ready_i (rs_rdy[0]),
        .rsp0_data_o  (rsd[0]),
        .rsp1_valid_o (rsv[1]),
        .rsp1_ready_i (rs_rdy[1]),
        .rsp1_data_o  (rsd[1]),
        .alu_data_a_o (alu_data_a_o),
        .alu_data_b_o (alu_data_b_o),
        .alu_inst_o   (alu_inst_o),
        .alu_data_i   (alu_data_i)
`ifdef ALU_ARB_PERF_EN
        ,
        .grant0_cnt_o (gc0),
        .grant1_cnt_o (gc1)
`endif
    );

    initial forever #5 clk_p_i = ~clk_p_i;

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] alu_f(input logic [2:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            3'b001:  return 16'(b) - 16'(a);
            3'b010:  return 16'(a) * 16'(b);
            3'b011:  return 16'(a & b);
            3'b100:  return 16'(a ^ b);
            3'b101:  return 16'(a | b);
            3'b110:  return 16'(a);
            3'b111:  return 16'(a) + 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // External ALU: result appears two cycles after operands are driven.
    always @(posedge clk_p_i) begin
        alu_s1 <= alu_f(alu_inst_o, alu_data_a_o, alu_data_b_o);
        alu_s2 <= alu_s1;
    end
    assign alu_data_i = alu_s2;

    always @(posedge clk_p_i) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int n);
        return (n != 0) ? q1.size() : q0.size();
    endfunction

    function automatic exp_t qfront(input int n);
        return (n != 0) ? q1[0] : q0[0];
    endfunction

    task automatic qpush(input int n, input exp_t e);
        if (n != 0) q1.push_back(e);
        else q0.push_back(e);
    endtask

    task automatic qpop(input int n);
        if (n != 0) void'(q1.pop_front());
        else void'(q0.pop_front());
    endtask

    // Issue side: model eligibility/round-robin and push expectations.
    always begin : mon_issue
        logic e0, e1, g0, g1;
        logic [18:0] exp_bus;
        exp_t e;
        @(negedge clk_p_i);
        #4;
        if (!reset_n_i) begin
            q0.delete();
            q1.delete();
            rel = 0;
            mcred = '{0, 0};
            gm = '{0, 0};
            mlast = 1;
            check("rst_ready", {30'b0, rdy[1], rdy[0]}, 0);
            check("rst_alu", {13'b0, alu_data_a_o, alu_data_b_o,
                              alu_inst_o}, 0);
        end else begin
            e0 = rq_v[0] && rel > 0 && mcred[0] < DEPTH;
            e1 = rq_v[1] && rel > 0 && mcred[1] < DEPTH;
            g0 = e0 && (!e1 || mlast == 1);
            g1 = e1 && (!e0 || mlast == 0);
            check("ready0", {31'b0, rdy[0]}, {31'b0, g0});
            check("ready1", {31'b0, rdy[1]}, {31'b0, g1});
            exp_bus = '0;
            for (int n = 0; n < 2; n++) begin
                if (rq_v[n] && rdy[n]) begin
                    exp_bus = {rq_a[n], rq_b[n], rq_op[n]};
                    e.d = alu_f(rq_op[n], rq_a[n], rq_b[n]);
                    e.acc = cyc;
                    qpush(n, e);
                    mcred[n]++;
                    mlast = n;
                    acc_cnt[n]++;
                    gm[n]++;
                    log_q.push_back(n);
                end
            end
            check("alu_bus", {13'b0, alu_data_a_o, alu_data_b_o,
                              alu_inst_o}, {13'b0, exp_bus});
            for (int n = 0; n < 2; n++)
                if (rsv[n] && rs_rdy[n]) mcred[n]--;
            rel++;
        end
    end

    // Response side: pop and compare whenever a result is presented.
    always begin : mon_rsp
        exp_t e;
        @(negedge clk_p_i);
        #4;
        if (!reset_n_i) begin
            check("rst_rsp_valid", {30'b0, rsv[1], rsv[0]}, 0);
            check("rst_rsp_data", {rsd[1], rsd[0]}, 0);
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (rsv[n]) begin
                    check($sformatf("rsp%0d_expected", n),
                          {31'b0, qsize(n) != 0}, 1);
                    if (qsize(n) != 0) begin
                        e = qfront(n);
                        check($sformatf("rsp%0d_data", n), {16'b0, rsd[n]},
                              {16'b0, e.d});
                        check($sformatf("rsp%0d_early", n),
                              {31'b0, cyc >= e.acc + 3}, 1);
                        if (rs_rdy[n]) begin
                            qpop(n);
                            pops[n]++;
                        end
                    end
                end else if (qsize(n) != 0) begin
                    e = qfront(n);
                    if (cyc >= e.acc + 3)
                        check($sformatf("rsp%0d_late", n), {31'b0, rsv[n]}, 1);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input int n, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] op,
                         output int acc);
        acc = -1;
        rq_v[n] = 1'b1;
        rq_a[n] = a;
        rq_b[n] = b;
        rq_op[n] = op;
        for (int k = 0; k < 40; k++) begin
            #4;
            if (rdy[n]) begin
                acc = cyc;
                break;
            end
            @(negedge clk_p_i);
        end
        if (acc < 0) check("issue_timeout", 1, 0);
        @(negedge clk_p_i);
        rq_v[n] = 1'b0;
    endtask

    task automatic wait_rsp(input int n, output int c,
                            output logic [15:0] d);
        c = -1;
        d = '0;
        for (int k = 0; k < 40; k++) begin
            #4;
            if (rsv[n]) begin
                c = cyc;
                d = rsd[n];
                break;
            end
            @(negedge clk_p_i);
        end
        if (c < 0) check("rsp_timeout", 1, 0);
        @(negedge clk_p_i);
    endtask

    task automatic rand_ops();
        for (int n = 0; n < 2; n++) begin
            rq_a[n] = 8'($urandom);
            rq_b[n] = 8'($urandom);
            rq_op[n] = 3'($urandom_range(0, 7));
        end
    endtask

    initial begin
        int acc, c, a0, a1, p1;
        logic [15:0] d;
        repeat (3) @(negedge clk_p_i);
        reset_n_i = 1'b1;

        // Single SUB, latency from acceptance to response.
        issue(0, 8'h03, 8'h0A, 3'b001, acc);
        wait_rsp(0, c, d);
        check("lat_req0", c - acc, 3);
        check("sub_data", {16'b0, d}, 32'h0007);

        // Two back-to-back requests on req1 return in order.
        issue(1, 8'hFF, 8'hFF, 3'b010, acc);
        issue(1, 8'h80, 8'h00, 3'b101, acc);
        wait_rsp(1, c, d);
        check("mul_data", {16'b0, d}, 32'hFE01);
        wait_rsp(1, c, d);
        check("or_data", {16'b0, d}, 32'h0080);

        // Reset with two requests in flight.
        repeat (5) @(negedge clk_p_i);
        a0 = acc_cnt[0] + acc_cnt[1];
        rand_ops();
        rq_v = '{1'b1, 1'b1};
        repeat (2) @(negedge clk_p_i);
        rq_v = '{1'b0, 1'b0};
        reset_n_i = 1'b0;
        check("inflight_accepts", acc_cnt[0] + acc_cnt[1] - a0, 2);
        @(negedge clk_p_i);
        reset_n_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #4;
            check("post_rst_quiet", {30'b0, rsv[1], rsv[0]}, 0);
            @(negedge clk_p_i);
        end

        // Both requesters streaming: strict alternation from req0.
        log_q.delete();
        rq_v = '{1'b1, 1'b1};
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            @(negedge clk_p_i);
        end
        rq_v = '{1'b0, 1'b0};
        for (int k = 0; k < 8; k++)
            check("alternation", (log_q.size() > k) ? log_q[k] : 9, k % 2);

        // Backpressure on req1 stops it at the credit limit only.
        repeat (8) @(negedge clk_p_i);
        rs_rdy[1] = 1'b0;
        a1 = acc_cnt[1];
        rq_v[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rand_ops();
            @(negedge clk_p_i);
        end
        check("bp_req1_accepts", acc_cnt[1] - a1, 4);
        #4;
        check("bp_req1_ready", {31'b0, rdy[1]}, 0);
        @(negedge clk_p_i);
        a0 = acc_cnt[0];
        rq_v[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rand_ops();
            @(negedge clk_p_i);
        end
        rq_v = '{1'b0, 1'b0};
        check("bp_req0_accepts", acc_cnt[0] - a0, 6);
        check("bp_req1_held", acc_cnt[1] - a1, 4);
        p1 = pops[1];
        rs_rdy[1] = 1'b1;
        repeat (10) @(negedge clk_p_i);
        check("bp_drain", pops[1] - p1, 4);

        // Randomised traffic with random response backpressure.
        for (int k = 0; k < 400; k++) begin
            rand_ops();
            rq_v[0] = ($urandom_range(0, 9) < 7);
            rq_v[1] = ($urandom_range(0, 9) < 7);
            rs_rdy[0] = ($urandom_range(0, 3) != 0);
            rs_rdy[1] = ($urandom_range(0, 3) != 0);
            @(negedge clk_p_i);
        end
        rq_v = '{1'b0, 1'b0};
        rs_rdy = '{1'b1, 1'b1};
        repeat (20) @(negedge clk_p_i);
        check("final_q0_empty", q0.size(), 0);
        check("final_q1_empty", q1.size(), 0);
`ifdef ALU_ARB_PERF_EN
        check("grant0_cnt", {16'b0, gc0}, gm[0]);
        check("grant1_cnt", {16'b0, gc1}, gm[1]);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
